ifu: RTL and testbench

Instruction fetch stage of the NPC core. Holds the architectural PC, issues one fetch per instruction to the instruction memory over a valid/ready request/response port, and presents `{pc, inst}` to the decode stage on the IF→ID channel. It then waits for the next PC returned by decode on the ID→IF channel before fetching again, so exactly one instruction is in flight between IF and ID.

---
 rtl/ifu.sv | 75 +++++++
 tb/tb_ifu.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ifu.sv
// ifu: instruction fetch stage. It fetches one instruction at a time, hands it to decode,
// and then waits for decode to return the next PC.
module ifu #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic                             if_to_id_valid,
    input  logic                             id_to_if_ready,
    output logic [DATA_WIDTH+ADDR_WIDTH-1:0] if_to_id_bus,
    input  logic                             id_to_if_valid,
    output logic                             if_to_id_ready,
    input  logic [ADDR_WIDTH-1:0]            id_to_if_bus,
    output logic                             imem_req_valid,
    input  logic                             imem_req_ready,
    output logic [ADDR_WIDTH-1:0]            imem_req_addr,
    input  logic                             imem_resp_valid,
    output logic                             imem_resp_ready,
    input  logic [DATA_WIDTH-1:0]            imem_resp_data,
    input  logic                             imem_resp_err,
    output logic                             misalign,
    output logic [63:0]                      inst_count
);
    typedef enum logic [1:0] {S_REQ, S_RESP, S_SEND, S_NPC} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [DATA_WIDTH-1:0]   inst;
    logic                    req_fire, resp_fire, send_fire, npc_fire;

    // Each handshake fires only in the state that owns it, so stray inputs are ignored.
    assign req_fire  = state == S_REQ  && imem_req_ready;
    assign resp_fire = state == S_RESP && imem_resp_valid;
    assign send_fire = state == S_SEND && id_to_if_ready;
    assign npc_fire  = state == S_NPC  && id_to_if_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            inst       <= '0;
            inst_count <= '0;
            misalign   <= 1'b0;
        end else begin
            state    <= state_nxt;
            misalign <= npc_fire && (id_to_if_bus[1:0] != 2'b00);
            if (resp_fire)
                inst <= imem_resp_err ? '0 : imem_resp_data;
            if (send_fire)
                inst_count <= inst_count + 64'd1;
            if (npc_fire)
                pc <= {id_to_if_bus[ADDR_WIDTH-1:2], 2'b00};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ:   state_nxt = req_fire  ? S_RESP : S_REQ;
            S_RESP:  state_nxt = resp_fire ? S_SEND : S_RESP;
            S_SEND:  state_nxt = send_fire ? S_NPC  : S_SEND;
            default: state_nxt = npc_fire  ? S_REQ  : S_NPC;
        endcase
    end

    // Handshake outputs decode the registered state only; reset simply masks them.
    assign imem_req_valid  = !rst && state == S_REQ;
    assign imem_resp_ready = !rst && state == S_RESP;
    assign if_to_id_valid  = !rst && state == S_SEND;
    assign if_to_id_ready  = !rst && state == S_NPC;
    assign imem_req_addr   = pc;
    assign if_to_id_bus    = {pc, inst};
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: table-driven cycle checks of the fetch FSM plus hand-written reset and
// bounded-wait sequences.
module tb_ifu;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_to_id_valid, id_to_if_ready;
    logic [63:0] if_to_id_bus;
    logic        id_to_if_valid, if_to_id_ready;
    logic [31:0] id_to_if_bus;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid, imem_resp_ready;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        misalign;
    logic [63:0] inst_count;
    int          checks = 0;
    int          passed = 0;

    localparam logic [3:0] R = 4'b1000, P = 4'b0100, S = 4'b0010, N = 4'b0001, Z = 4'b0000;

    typedef struct {
        logic        rr, rv;
        logic [31:0] rd;
        logic        re, ir, iv;
        logic [31:0] nb;
        logic [3:0]  hs;
        logic [31:0] pc, inst;
        logic        mis;
        logic [63:0] cnt;
    } vec_t;

    vec_t v[26];

    ifu dut (
        .clk(clk), .rst(rst),
        .if_to_id_valid(if_to_id_valid), .id_to_if_ready(id_to_if_ready),
        .if_to_id_bus(if_to_id_bus),
        .id_to_if_valid(id_to_if_valid), .if_to_id_ready(if_to_id_ready),
        .id_to_if_bus(id_to_if_bus),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_ready(imem_resp_ready),
        .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
        .misalign(misalign), .inst_count(inst_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t row(input logic rr, rv, input logic [31:0] rd, input logic re, ir, iv,
                                 input logic [31:0] nb, input logic [3:0] hs,
                                 input logic [31:0] pc, inst, input logic mis, input logic [63:0] cnt);
        row = '{rr, rv, rd, re, ir, iv, nb, hs, pc, inst, mis, cnt};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic rr, rv, input logic [31:0] rd, input logic re, ir, iv,
                         input logic [31:0] nb);
        imem_req_ready  = rr;
        imem_resp_valid = rv;
        imem_resp_data  = rd;
        imem_resp_err   = re;
        id_to_if_ready  = ir;
        id_to_if_valid  = iv;
        id_to_if_bus    = nb;
    endtask

    function automatic logic [3:0] hs();
        hs = {imem_req_valid, imem_resp_ready, if_to_id_valid, if_to_id_ready};
    endfunction

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        v[0]  = row(1, 0, 0,            0, 0, 0, 0,            R, 32'h8000_0000, 0,            0, 0);
        v[1]  = row(0, 1, 32'h0000_0413, 0, 0, 0, 0,           P, 32'h8000_0000, 0,            0, 0);
        v[2]  = row(0, 0, 0,            0, 1, 0, 0,            S, 32'h8000_0000, 32'h0000_0413, 0, 0);
        v[3]  = row(0, 0, 0,            0, 0, 1, 32'h8000_0010, N, 32'h8000_0000, 32'h0000_0413, 0, 1);
        v[4]  = row(0, 0, 0,            0, 0, 0, 0,            R, 32'h8000_0010, 32'h0000_0413, 0, 1);
        v[5]  = row(0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0,           R, 32'h8000_0010, 32'h0000_0413, 0, 1);
        v[6]  = row(0, 0, 0,            0, 1, 1, 0,            R, 32'h8000_0010, 32'h0000_0413, 0, 1);
        v[7]  = row(0, 0, 0,            0, 0, 0, 0,            R, 32'h8000_0010, 32'h0000_0413, 0, 1);
        v[8]  = row(0, 0, 0,            0, 0, 0, 0,            R, 32'h8000_0010, 32'h0000_0413, 0, 1);
        v[9]  = row(1, 0, 0,            0, 0, 0, 0,            R, 32'h8000_0010, 32'h0000_0413, 0, 1);
        v[10] = row(0, 1, 32'h0000_0093, 0, 0, 0, 0,           P, 32'h8000_0010, 32'h0000_0413, 0, 1);
        v[11] = row(0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0,           S, 32'h8000_0010, 32'h0000_0093, 0, 1);
        v[12] = row(0, 0, 0,            0, 0, 1, 32'h1234_5678, S, 32'h8000_0010, 32'h0000_0093, 0, 1);
        v[13] = row(0, 0, 0,            0, 0, 0, 0,            S, 32'h8000_0010, 32'h0000_0093, 0, 1);
        v[14] = row(0, 0, 0,            0, 1, 0, 0,            S, 32'h8000_0010, 32'h0000_0093, 0, 1);
        v[15] = row(0, 0, 0,            0, 0, 0, 0,            N, 32'h8000_0010, 32'h0000_0093, 0, 2);
        v[16] = row(0, 0, 0,            0, 0, 1, 32'h8000_0020, N, 32'h8000_0010, 32'h0000_0093, 0, 2);
        v[17] = row(1, 0, 0,            0, 0, 0, 0,            R, 32'h8000_0020, 32'h0000_0093, 0, 2);
        v[18] = row(0, 0, 0,            0, 0, 0, 0,            P, 32'h8000_0020, 32'h0000_0093, 0, 2);
        v[19] = row(0, 1, 32'hFFFF_FFFF, 1, 0, 0, 0,           P, 32'h8000_0020, 32'h0000_0093, 0, 2);
        v[20] = row(0, 0, 0,            0, 1, 0, 0,            S, 32'h8000_0020, 0,            0, 2);
        v[21] = row(0, 0, 0,            0, 0, 1, 32'h8000_0006, N, 32'h8000_0020, 0,            0, 3);
        v[22] = row(1, 0, 0,            0, 0, 0, 0,            R, 32'h8000_0004, 0,            1, 3);
        v[23] = row(0, 1, 32'h0000_0013, 0, 0, 0, 0,           P, 32'h8000_0004, 0,            0, 3);
        v[24] = row(0, 0, 0,            0, 1, 0, 0,            S, 32'h8000_0004, 32'h0000_0013, 0, 3);
        v[25] = row(0, 0, 0,            0, 0, 0, 0,            N, 32'h8000_0004, 32'h0000_0013, 0, 4);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_handshakes", {60'd0, hs()}, {60'd0, Z});
        chk("reset_count", inst_count, 64'd0);
        chk("reset_misalign", {63'd0, misalign}, 64'd0);
        rst = 1'b0;
        #1;
        chk("first_req_after_reset", {60'd0, hs()}, {60'd0, R});
        @(negedge clk);

        for (int i = 0; i < 26; i++) begin
            chk($sformatf("v%0d_hs", i), {60'd0, hs()}, {60'd0, v[i].hs});
            chk($sformatf("v%0d_addr", i), {32'd0, imem_req_addr}, {32'd0, v[i].pc});
            chk($sformatf("v%0d_bus", i), if_to_id_bus, {v[i].pc, v[i].inst});
            chk($sformatf("v%0d_misalign", i), {63'd0, misalign}, {63'd0, v[i].mis});
            chk($sformatf("v%0d_count", i), inst_count, v[i].cnt);
            drive(v[i].rr, v[i].rv, v[i].rd, v[i].re, v[i].ir, v[i].iv, v[i].nb);
            @(negedge clk);
        end

        // Reset while a response is pending in S_RESP.
        drive(0, 0, 0, 0, 0, 1, 32'h8000_0030);
        @(negedge clk);
        chk("pre_rst_req", {60'd0, hs()}, {60'd0, R});
        chk("pre_rst_addr", {32'd0, imem_req_addr}, 64'h8000_0030);
        drive(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("pre_rst_resp", {60'd0, hs()}, {60'd0, P});
        rst = 1'b1;
        drive(0, 1, 32'h0000_0ABC, 0, 1, 1, 32'h9000_0000);
        #1;
        chk("rst_masks_outputs", {60'd0, hs()}, {60'd0, Z});
        @(negedge clk);
        chk("in_rst_outputs", {60'd0, hs()}, {60'd0, Z});
        chk("in_rst_count", inst_count, 64'd0);
        rst = 1'b0;
        drive(0, 1, 32'h0000_0ABC, 0, 0, 0, 0);
        #1;
        chk("post_rst_req", {60'd0, hs()}, {60'd0, R});
        chk("post_rst_addr", {32'd0, imem_req_addr}, 64'h8000_0000);
        @(negedge clk);
        chk("stale_resp_ignored_hs", {60'd0, hs()}, {60'd0, R});
        chk("stale_resp_ignored_bus", if_to_id_bus, {32'h8000_0000, 32'h0});
        chk("post_rst_count", inst_count, 64'd0);

        // Bounded wait for the fresh instruction to reach decode.
        drive(1, 1, 32'h0000_0013, 0, 0, 0, 0);
        begin
            int n;
            n = 0;
            while (!if_to_id_valid && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("fresh_send_reached", {63'd0, if_to_id_valid}, 64'd1);
            chk("fresh_send_latency", 64'(n), 64'd2);
            chk("fresh_send_bus", if_to_id_bus, {32'h8000_0000, 32'h0000_0013});
            chk("fresh_send_count", inst_count, 64'd0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
